// File: rtl/timer_responder_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// FSM state codes, mode codes and the PRESET byte-merge helper.
// Optional feature macro: TIMER_PRESCALE_EN (adds CTRL[7:4] prescale field).
package timer_responder_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] TIMER_CTRL   = 2'b00;
    localparam logic [1:0] TIMER_PRESET = 2'b01;
    localparam logic [1:0] TIMER_COUNT  = 2'b10;

    // FSM state codes
    typedef enum logic [1:0] {
        TIMER_IDLE = 2'b00,
        TIMER_LOAD = 2'b01,
        TIMER_CNT  = 2'b10,
        TIMER_INT  = 2'b11
    } timer_state_e;

    // CTRL.MODE codes; 2'b1x behaves as one-shot
    localparam logic [1:0] TIMER_ONESHOT = 2'b00;
    localparam logic [1:0] TIMER_RELOAD  = 2'b01;

    // Writable CTRL bits: EN/MODE/IM always, PS only with the prescaler built in
`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

    // Replace only the byte lanes whose enable is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_responder_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every 2^ps cycles.
// Restart clears the divider so the first tick after a reload is a full period.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module tick_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [3:0] ps,
    output logic       tick
);

    logic [14:0] div_q;
    logic [14:0] mask;

    // Low ps bits all set marks the last cycle of each 2^ps period; ps=0 ticks always
    assign mask = ~(15'h7FFF << ps);
    assign tick = (div_q & mask) == mask;

    // Divider counter, cleared on restart
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (restart) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 15'd1;
        end
    end

endmodule

// File: rtl/timer_responder.sv
// Memory-mapped countdown timer on the CPU data bus with one interrupt line.
// CTRL/PRESET/COUNT registers, IDLE->LOAD->CNT->INT FSM, one-shot and
// auto-reload modes. Optional macro: TIMER_PRESCALE_EN (CTRL[7:4] prescaler).
module timer_responder
    import timer_responder_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    timer_state_e state, next_state;
    logic [7:0]   ctrl_q;
    logic [31:0]  preset_q;
    logic [31:0]  count_q;
    logic         pending_q;

    logic         wr_en, ctrl_wr, preset_wr, force_idle;
    logic         en, im, is_reload, tick;
    logic [7:0]   ctrl_new;

    assign wr_en     = sel && (|byteen);
    assign ctrl_wr   = wr_en && (addr[3:2] == TIMER_CTRL);
    assign preset_wr = wr_en && (addr[3:2] == TIMER_PRESET);

    // CTRL lives entirely in byte lane 0
    assign ctrl_new   = byteen[0] ? (wdata[7:0] & CTRL_WMASK) : ctrl_q;
    // A CTRL write that clears EN overrides whatever the FSM was doing
    assign force_idle = ctrl_wr && byteen[0] && !wdata[0];

    assign en        = ctrl_q[0];
    assign im        = ctrl_q[3];
    assign is_reload = (ctrl_q[2:1] == TIMER_RELOAD);

`ifdef TIMER_PRESCALE_EN
    tick_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (state == TIMER_LOAD),
        .ps      (ctrl_q[7:4]),
        .tick    (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Only addr[3:2] selects a register
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= TIMER_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a CTRL write with EN=0 forces IDLE from any state
    // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            TIMER_IDLE: if (en) next_state = TIMER_LOAD;
            TIMER_LOAD: next_state = TIMER_CNT;
            TIMER_CNT: begin
                if (!en)                next_state = TIMER_IDLE;
                else if (count_q == '0) next_state = TIMER_INT;
            end
            TIMER_INT:  next_state = is_reload ? TIMER_LOAD : TIMER_IDLE;
            default:    next_state = TIMER_IDLE;
        endcase
        if (force_idle) next_state = TIMER_IDLE;
    end

    // CTRL: bus write wins over the one-shot EN clear in INT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else if (ctrl_wr) begin
            ctrl_q <= ctrl_new;
        end else if (state == TIMER_INT && !is_reload) begin
            ctrl_q[0] <= 1'b0;
        end
    end

    // PRESET: byte-merged write; only sampled by the counter in LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_q <= RESET_PRESET;
        end else if (preset_wr) begin
            preset_q <= merge_bytes(preset_q, wdata, byteen);
        end
    end

    // COUNT: load in LOAD, decrement only while staying in CNT (never below 0, frozen on exit)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (state == TIMER_LOAD) begin
            count_q <= preset_q;
        end else if (state == TIMER_CNT && next_state == TIMER_CNT && tick) begin
            count_q <= count_q - 32'd1;
        end
    end

    // One-shot pending flag: set on entry to INT, cleared by any CTRL/PRESET write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
        end else if (ctrl_wr || preset_wr) begin
            pending_q <= 1'b0;
        end else if (state == TIMER_CNT && next_state == TIMER_INT && !is_reload) begin
            pending_q <= 1'b1;
        end
    end

    // Read mux, combinational from addr[3:2]
    always_comb begin
        rdata = '0;
        case (addr[3:2])
            TIMER_CTRL:   rdata = {24'd0, ctrl_q};
            TIMER_PRESET: rdata = preset_q;
            TIMER_COUNT:  rdata = count_q;
            default:      rdata = '0;
        endcase
    end

    assign irq = im && (pending_q || (state == TIMER_INT && is_reload));

endmodule

// File: tb/tb_timer_responder.sv
// Directed, scoreboard-driven bench for timer_responder.
// Optional macro: TIMER_PRESCALE_EN (enables the prescaler checks).
module tb_timer_responder;

    localparam logic [31:0] RST_PRESET = 32'h0000_00C8;
    localparam logic [31:0] A_CTRL     = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET   = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT    = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD     = 32'h0000_7F0C;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    timer_responder #(.RESET_PRESET(RST_PRESET)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h required nothing", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        expect_val(tag, exp);
        addr = a;
        #1;
        observe(rdata);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        expect_val(tag, {31'd0, exp});
        observe({31'd0, irq});
    endtask

    // Write lands on the next rising edge; returns 1 ns after it
    task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        sel    = 1'b1;
        addr   = a;
        byteen = be;
        wdata  = d;
        @(posedge clk);
        #1;
        sel    = 1'b0;
        byteen = 4'b0000;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        sel    = 1'b0;
        addr   = '0;
        byteen = '0;
        wdata  = '0;

        // 1. Reset state
        #1;
        check_irq("irq_in_reset", 1'b0);
        cycles(2);
        reset = 1'b1;
        check_reg("rst_ctrl", A_CTRL, 32'h0);
        check_reg("rst_preset", A_PRESET, RST_PRESET);
        check_reg("rst_count", A_COUNT, 32'h0);
        check_reg("rst_rsvd", A_RSVD, 32'h0);
        check_irq("rst_irq", 1'b0);

        // 2. One-shot, PRESET=5: INT 8 cycles after the CTRL write edge
        bus_write(A_PRESET, 4'b1111, 32'd5);
        bus_write(A_CTRL, 4'b1111, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            cycles(1);
            check_reg($sformatf("os_count_k%0d", k), A_COUNT,
                      (k < 2) ? 32'd0 : (k >= 7) ? 32'd0 : 32'(5 - (k - 2)));
            check_irq($sformatf("os_irq_k%0d", k), k == 8);
        end
        cycles(1);
        check_reg("os_en_cleared", A_CTRL, 32'h8);
        check_irq("os_irq_held1", 1'b1);
        cycles(3);
        check_irq("os_irq_held2", 1'b1);
        bus_write(A_CTRL, 4'b0001, 32'h0);
        check_irq("os_irq_cleared", 1'b0);
        check_reg("os_ctrl_after_clr", A_CTRL, 32'h0);

        // 3. Auto-reload, PRESET=3: 1-cycle pulses every 6 cycles, then masked
        bus_write(A_PRESET, 4'b1111, 32'd3);
        bus_write(A_CTRL, 4'b1111, 32'hB);
        for (int k = 1; k <= 19; k++) begin
            cycles(1);
            check_irq($sformatf("ar_irq_k%0d", k), (k >= 6) && ((k - 6) % 6 == 0));
            if (k == 8) check_reg("ar_reload_count", A_COUNT, 32'd3);
        end
        bus_write(A_CTRL, 4'b0001, 32'h3);
        for (int k = 0; k < 12; k++) begin
            check_irq($sformatf("ar_masked_k%0d", k), 1'b0);
            cycles(1);
        end
        bus_write(A_CTRL, 4'b0001, 32'h0);

        // 4. Mid-count disable, byte-lane writes, read-only/reserved registers
        bus_write(A_PRESET, 4'b1111, 32'd10);
        bus_write(A_CTRL, 4'b1111, 32'h1);
        cycles(5);
        check_reg("mid_count_before", A_COUNT, 32'd7);
        bus_write(A_CTRL, 4'b0001, 32'h0);
        check_reg("mid_count_frozen", A_COUNT, 32'd7);
        check_reg("mid_ctrl_off", A_CTRL, 32'h0);
        cycles(3);
        check_reg("mid_count_still", A_COUNT, 32'd7);
        check_reg("mid_preset_kept", A_PRESET, 32'd10);
        bus_write(A_PRESET, 4'b0011, 32'hDEAD_BEEF);
        check_reg("preset_low_half", A_PRESET, 32'h0000_BEEF);
        bus_write(A_PRESET, 4'b1100, 32'h1234_5678);
        check_reg("preset_high_half", A_PRESET, 32'h1234_BEEF);
        bus_write(A_COUNT, 4'b1111, 32'hFFFF_FFFF);
        check_reg("count_write_ignored", A_COUNT, 32'd7);
        bus_write(A_RSVD, 4'b1111, 32'hFFFF_FFFF);
        check_reg("rsvd_reads_zero", A_RSVD, 32'h0);
        bus_write(A_CTRL, 4'b0001, 32'hF0);
`ifdef TIMER_PRESCALE_EN
        check_reg("ctrl_ps_field", A_CTRL, 32'hF0);
`else
        check_reg("ctrl_ps_field", A_CTRL, 32'h0);
`endif
        bus_write(A_CTRL, 4'b0001, 32'h0);

        // 5. CTRL write in the cycle the one-shot FSM clears EN
        bus_write(A_PRESET, 4'b1111, 32'd2);
        bus_write(A_CTRL, 4'b1111, 32'h9);
        cycles(5);
        check_irq("race_int_irq", 1'b1);
        check_reg("race_count_zero", A_COUNT, 32'd0);
        bus_write(A_CTRL, 4'b1111, 32'h9);
        check_reg("race_en_kept", A_CTRL, 32'h9);
        check_irq("race_pending_cleared", 1'b0);
        cycles(2);
        check_reg("race_reloaded", A_COUNT, 32'd2);
        check_irq("race_irq_low", 1'b0);
        cycles(2);
        check_irq("race_irq_before", 1'b0);
        cycles(1);
        check_irq("race_irq_again", 1'b1);

        // Reset asserted with irq pending: drops without a clock edge
        reset = 1'b0;
        #1;
        check_irq("async_rst_irq", 1'b0);
        check_reg("async_rst_count", A_COUNT, 32'd0);
        check_reg("async_rst_ctrl", A_CTRL, 32'h0);
        check_reg("async_rst_preset", A_PRESET, RST_PRESET);
        reset = 1'b1;
        cycles(2);
        check_irq("post_rst_irq", 1'b0);

`ifdef TIMER_PRESCALE_EN
        // 6. PS=2, PRESET=2: decrement every 4 cycles
        bus_write(A_PRESET, 4'b1111, 32'd2);
        bus_write(A_CTRL, 4'b0001, 32'h29);
        cycles(5);
        check_reg("ps_count_t5", A_COUNT, 32'd2);
        cycles(1);
        check_reg("ps_count_t6", A_COUNT, 32'd1);
        cycles(3);
        check_reg("ps_count_t9", A_COUNT, 32'd1);
        cycles(1);
        check_reg("ps_count_t10", A_COUNT, 32'd0);
        check_irq("ps_irq_t10", 1'b0);
        cycles(1);
        check_irq("ps_irq_t11", 1'b1);
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
